// File: rtl/fsm_eg_ab_driver_pkg.sv
// Shared encodings for the fsm_eg a/b driver: target states, command codes
// and the driver's own sequencing states.
package fsm_eg_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } tgt_state_e;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_STEP_A  = 2'b01,
        CMD_STEP_AB = 2'b10,
        CMD_GOTO_S0 = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } drv_state_e;

endpackage

// File: rtl/fsm_eg_ab_driver_if.sv
// Command, drive and response bundle between the command source, the driver
// and the fsm_eg target.
interface fsm_eg_ab_driver_if #(
    parameter int ERR_CNT_W = 4
);
    logic                 start_amisha;
    logic [1:0]           cmd_amisha;
    logic                 y0_amisha;
    logic                 y1_amisha;
    logic                 a_amisha;
    logic                 b_amisha;
    logic                 busy_amisha;
    logic                 done_amisha;
    logic                 err_amisha;
    logic [ERR_CNT_W-1:0] err_cnt_amisha;
    logic [1:0]           state_amisha;

    modport master (
        output start_amisha, cmd_amisha, y0_amisha, y1_amisha,
        input  a_amisha, b_amisha, busy_amisha, done_amisha,
               err_amisha, err_cnt_amisha, state_amisha
    );

    modport slave (
        input  start_amisha, cmd_amisha, y0_amisha, y1_amisha,
        output a_amisha, b_amisha, busy_amisha, done_amisha,
               err_amisha, err_cnt_amisha, state_amisha
    );
endinterface

// File: rtl/fsm_eg_ab_driver_ref_model.sv
// Combinational golden function of the fsm_eg target:
// (state, a, b) -> (next_state, expected Mealy y0, expected Moore y1).
module fsm_eg_ref_model
    import fsm_eg_pkg::*;
(
    input  tgt_state_e state,
    input  logic       a,
    input  logic       b,
    output tgt_state_e next_state,
    output logic       exp_y0,
    output logic       exp_y1
);

    always_comb begin
        next_state = S0;
        case (state)
            S0: begin
                if (a && b)  next_state = S2;
                else if (a)  next_state = S1;
                else         next_state = S0;
            end
            S1:      next_state = a ? S0 : S1;
            default: next_state = S0;
        endcase
        exp_y0 = (state == S0) && a && b;
        exp_y1 = (state == S1) || (state == S2);
    end

endmodule

// File: rtl/fsm_eg_ab_driver.sv
// Command-driven a/b stimulus source for the fsm_eg target with a shadow
// model of its state and registered y0/y1 response checking.
module fsm_eg_ab_driver
    import fsm_eg_pkg::*;
#(
    parameter int ERR_CNT_W = 4,
    parameter bit CHECK_EN  = 1'b1
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    fsm_eg_ab_driver_if.slave bus
);

    drv_state_e           drv_q, drv_d;
    tgt_state_e           model_q, model_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic                 busy_q, done_q;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 mis;

    tgt_state_e drv_next, chk_next;
    logic       drv_y0, drv_y1, chk_y0, chk_y1;

    fsm_eg_ref_model u_ref_drive (
        .state      (model_q),
        .a          (a_q),
        .b          (b_q),
        .next_state (drv_next),
        .exp_y0     (drv_y0),
        .exp_y1     (drv_y1)
    );

    // CHECK drives a=b=0, so this instance retires S2 back to S0.
    fsm_eg_ref_model u_ref_check (
        .state      (model_q),
        .a          (1'b0),
        .b          (1'b0),
        .next_state (chk_next),
        .exp_y0     (chk_y0),
        .exp_y1     (chk_y1)
    );

    logic unused_ref_outs;
    assign unused_ref_outs = &{1'b0, drv_y1, chk_y0};

    always_comb begin
        drv_d   = drv_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        model_d = model_q;
        case (drv_q)
            IDLE: begin
                if (bus.start_amisha) begin
                    drv_d = DRIVE;
                    case (cmd_e'(bus.cmd_amisha))
                        CMD_STEP_A:  a_d = 1'b1;
                        CMD_STEP_AB: begin
                            a_d = 1'b1;
                            b_d = 1'b1;
                        end
                        CMD_GOTO_S0: a_d = (model_q == S1);
                        default:     a_d = 1'b0;
                    endcase
                end
            end
            DRIVE: begin
                drv_d   = CHECK;
                model_d = drv_next;
            end
            CHECK: begin
                drv_d   = IDLE;
                model_d = chk_next;
            end
            default: drv_d = IDLE;
        endcase
    end

    // Each compare closes on a different edge, so at most one mismatch per cycle.
    always_comb begin
        mis   = 1'b0;
        err_d = err_q;
        cnt_d = cnt_q;
        if (CHECK_EN) begin
            mis = ((drv_q == DRIVE) && (bus.y0_amisha != drv_y0)) ||
                  ((drv_q == CHECK) && (bus.y1_amisha != chk_y1));
        end
        if (mis) begin
            err_d = 1'b1;
            if (!(&cnt_q)) cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            drv_q   <= IDLE;
            model_q <= S0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            drv_q   <= drv_d;
            model_q <= model_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= (drv_d != IDLE);
            done_q  <= (drv_d == CHECK);
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.a_amisha       = a_q;
    assign bus.b_amisha       = b_q;
    assign bus.busy_amisha    = busy_q;
    assign bus.done_amisha    = done_q;
    assign bus.err_amisha     = err_q;
    assign bus.err_cnt_amisha = cnt_q;
    assign bus.state_amisha   = model_q;

endmodule

// File: tb/tb_fsm_eg_ab_driver.sv
// Bench for fsm_eg_ab_driver: behavioural target with y0/y1 fault injection,
// directed vector table, randomized commands and reset corner cases.
module tb_fsm_eg_ab_driver;
    import fsm_eg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_eg_ab_driver_if #(.ERR_CNT_W(4)) bus();

    fsm_eg_ab_driver #(.ERR_CNT_W(4), .CHECK_EN(1'b1)) dut (
        .clk_amisha   (clk),
        .reset_amisha (rst),
        .bus          (bus)
    );

    // Behavioural target FSM on the same clock/reset; inj flips a response.
    int tgt;
    bit inj0, inj1;
    always @(posedge clk) begin
        if (rst) tgt <= 0;
        else begin
            case (tgt)
                0:       tgt <= (bus.a_amisha && bus.b_amisha) ? 2 : (bus.a_amisha ? 1 : 0);
                1:       tgt <= bus.a_amisha ? 0 : 1;
                default: tgt <= 0;
            endcase
        end
    end
    assign bus.y0_amisha = ((tgt == 0) && bus.a_amisha && bus.b_amisha) ^ inj0;
    assign bus.y1_amisha = (tgt != 0) ^ inj1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] cmd;
        bit inj0, inj1, poke;
        bit ea, eb;
        int mid, fin, cmid, cfin;
    } vec_t;
    vec_t tbl[9];

    // One full command: E0 accept, E1 closes DRIVE, E2 closes CHECK.
    task automatic do_cmd(input logic [1:0] c, input bit i0, input bit i1, input bit poke,
                          input bit ea, input bit eb, input int prior, input int mid,
                          input int fin, input int cprev, input int cmid, input int cfin);
        @(negedge clk);
        inj0 = i0; inj1 = i1;
        bus.start_amisha = 1'b1;
        bus.cmd_amisha   = c;
        @(negedge clk);
        bus.start_amisha = poke;
        chk("drive_a", bus.a_amisha, ea);
        chk("drive_b", bus.b_amisha, eb);
        chk("drive_busy", bus.busy_amisha, 1);
        chk("drive_done", bus.done_amisha, 0);
        chk("drive_state", bus.state_amisha, prior);
        chk("drive_cnt", bus.err_cnt_amisha, cprev);
        @(negedge clk);
        bus.start_amisha = 1'b0;
        chk("check_ab", {bus.a_amisha, bus.b_amisha}, 0);
        chk("check_done", bus.done_amisha, 1);
        chk("check_busy", bus.busy_amisha, 1);
        chk("check_state", bus.state_amisha, mid);
        chk("check_cnt", bus.err_cnt_amisha, cmid);
        chk("check_err", bus.err_amisha, cmid != 0);
        @(negedge clk);
        chk("idle_done", bus.done_amisha, 0);
        chk("idle_busy", bus.busy_amisha, 0);
        chk("idle_state", bus.state_amisha, fin);
        chk("idle_cnt", bus.err_cnt_amisha, cfin);
        chk("idle_err", bus.err_amisha, cfin != 0);
        inj0 = 1'b0; inj1 = 1'b0;
    endtask

    // Command-level reference: what one command does to the target state.
    function automatic void ref_cmd(input int st, input int c, output bit ea, output bit eb,
                                    output int mid, output int fin);
        ea = (c == 1) || (c == 2) || ((c == 3) && (st == 1));
        eb = (c == 2);
        if (!ea)          mid = st;
        else if (st == 0) mid = eb ? 2 : 1;
        else              mid = 0;
        fin = (mid == 2) ? 0 : mid;
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int rs, cnt, mid, fin, cm, cf, c;
        bit ea, eb, i0, i1;

        tbl[0] = '{2'b01, 0, 0, 0, 1, 0, 1, 1, 0, 0};
        tbl[1] = '{2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2] = '{2'b10, 0, 0, 0, 1, 1, 2, 0, 0, 0};
        tbl[3] = '{2'b10, 1, 0, 1, 1, 1, 2, 0, 1, 1};
        tbl[4] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[5] = '{2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[6] = '{2'b01, 0, 1, 0, 1, 0, 1, 1, 1, 2};
        tbl[7] = '{2'b01, 0, 0, 0, 1, 0, 0, 0, 2, 2};
        tbl[8] = '{2'b10, 1, 1, 0, 1, 1, 2, 0, 3, 4};

        bus.start_amisha = 1'b0;
        bus.cmd_amisha   = 2'b00;
        inj0 = 1'b0; inj1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_a", bus.a_amisha, 0);
            chk("rst_b", bus.b_amisha, 0);
            chk("rst_busy", bus.busy_amisha, 0);
            chk("rst_done", bus.done_amisha, 0);
            chk("rst_err", bus.err_amisha, 0);
            chk("rst_cnt", bus.err_cnt_amisha, 0);
            chk("rst_state", bus.state_amisha, 0);
        end

        for (int i = 0; i < 9; i++) begin
            do_cmd(tbl[i].cmd, tbl[i].inj0, tbl[i].inj1, tbl[i].poke, tbl[i].ea, tbl[i].eb,
                   (i == 0) ? 0 : tbl[i-1].fin, tbl[i].mid, tbl[i].fin,
                   (i == 0) ? 0 : tbl[i-1].cfin, tbl[i].cmid, tbl[i].cfin);
        end

        rs = tbl[8].fin;
        cnt = tbl[8].cfin;
        for (int i = 0; i < 40; i++) begin
            c  = int'($urandom_range(0, 3));
            i0 = ($urandom_range(0, 4) == 0);
            i1 = ($urandom_range(0, 4) == 0);
            ref_cmd(rs, c, ea, eb, mid, fin);
            cm = sat15(cnt + int'(i0));
            cf = sat15(cm + int'(i1));
            do_cmd(2'(c), i0, i1, ($urandom_range(0, 1) == 1), ea, eb, rs, mid, fin, cnt, cm, cf);
            rs = fin;
            cnt = cf;
        end

        for (int i = 0; i < 8; i++) begin
            ref_cmd(rs, 0, ea, eb, mid, fin);
            cm = sat15(cnt + 1);
            cf = sat15(cm + 1);
            do_cmd(2'b00, 1'b1, 1'b1, 1'b0, ea, eb, rs, mid, fin, cnt, cm, cf);
            rs = fin;
            cnt = cf;
        end
        chk("sat_cnt", bus.err_cnt_amisha, 15);

        // Reset lands while the driver is in DRIVE.
        @(negedge clk);
        bus.start_amisha = 1'b1;
        bus.cmd_amisha   = 2'b10;
        @(negedge clk);
        bus.start_amisha = 1'b0;
        chk("pre_rst_busy", bus.busy_amisha, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_a", bus.a_amisha, 0);
        chk("mid_rst_b", bus.b_amisha, 0);
        chk("mid_rst_busy", bus.busy_amisha, 0);
        chk("mid_rst_done", bus.done_amisha, 0);
        chk("mid_rst_err", bus.err_amisha, 0);
        chk("mid_rst_cnt", bus.err_cnt_amisha, 0);
        chk("mid_rst_state", bus.state_amisha, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", bus.done_amisha, 0);
            chk("post_rst_busy", bus.busy_amisha, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_eg_ab_driver.md
# fsm_eg_ab_driver

Command-driven stimulus source and response checker for the two-input fsm_eg target FSM (states S0/S1/S2, Moore output y1, Mealy output y0). It converts single-cycle commands into registered a/b drive cycles and tracks a model of the target's state. It checks the target's y0/y1 responses against that model and reports done, sticky error and a mismatch count. It sits on the a/b side of the target on the same clock and reset, so both leave reset in S0 together.

## Interface
- ERR_CNT_W, 4: width of the saturating mismatch counter.
- CHECK_EN, 1: 1 = compare y0/y1 and update err; 0 = drive only (err and err_cnt held at 0).
- clk_amisha  input  1  system clock, rising edge.
- reset_amisha  input  1  synchronous, active-high reset; also drives the target.
- start_amisha  input  1  command strobe; sampled only when busy_amisha=0.
- cmd_amisha  input  2  command code, sampled with start.
- y0_amisha  input  1  Mealy output from the target.
- y1_amisha  input  1  Moore output from the target.
- a_amisha  output  1  registered drive to the target's a input.
- b_amisha  output  1  registered drive to the target's b input.
- busy_amisha  output  1  high in DRIVE and CHECK.
- done_amisha  output  1  one-cycle pulse in CHECK.
- err_amisha  output  1  sticky mismatch flag; cleared only by reset.
- err_cnt_amisha  output  ERR_CNT_W  mismatch count; saturates at all-ones.
- state_amisha  output  2  model of the target's state (S0=00, S1=01, S2=10).

## Operation
- Reset: a=b=0, busy=0, done=0, err=0, err_cnt=0, state=S0, driver in IDLE. A reset mid-command aborts it: no done pulse, and all outputs take their reset values at the next edge.
- Commands and (a,b) loaded at acceptance:
  - 00 NOP: (0,0).
  - 01 STEP_A: (1,0).
  - 10 STEP_AB: (1,1).
  - 11 GOTO_S0: (model==S1, 0).
- Model next state, evaluated on the (a,b) values being driven:
  - S0: a&b → S2; a&~b → S1; ~a → S0.
  - S1: a → S0; ~a → S1.
  - S2: → S0 unconditionally.
- Expected outputs: y0 = (model==S0)&a&b; y1 = (model==S1 or model==S2).
- Driver FSM:
  - IDLE: a=b=0. On start, latch the command, register (a,b), go to DRIVE.
  - DRIVE: hold (a,b). At the closing edge, compare y0 against the expected y0 and update the model. Go to CHECK.
  - CHECK: a=b=0, done=1. At the closing edge, compare y1 against the expected y1 for the model state entered in DRIVE. Apply the model transition with a=b=0, so S2 → S0. Go to IDLE.
- After CHECK the model is always S0 or S1. In IDLE the model holds, because a=0 keeps the target where it is.
- Each mismatching compare sets err and increments err_cnt (saturating). A y0 and a y1 mismatch in the same command count as 2.
- start while busy: ignored, not queued.

## Timing
- Start sampled at edge E0. DRIVE occupies E0→E1; CHECK occupies E1→E2; IDLE from E2.
- a/b are valid in the cycle after start is sampled.
- done is high during E1→E2.
- The earliest next start is sampled at E2, so the throughput is one command per 3 cycles.
- err/err_cnt update on the edge that closes the failing compare:
  - y0 failure visible from E1.
  - y1 failure visible from E2.
- state_amisha updates at E1 and E2.
- All outputs are registered; there is no combinational path from y0/y1 to any output.

## Structure
- Package fsm_eg_pkg holds:
  - target-state encoding S0/S1/S2;
  - command codes CMD_NOP/CMD_STEP_A/CMD_STEP_AB/CMD_GOTO_S0;
  - driver-state encoding IDLE/DRIVE/CHECK.
- Sub-module fsm_eg_ref_model: purely combinational golden function, (state, a, b) → (next_state, exp_y0, exp_y1). The driver instantiates it once for the DRIVE evaluation and once for the CHECK evaluation (a=b=0).
- Top level holds the driver FSM, the drive registers, the model state register and the error logic.

## Test plan
- Reset held 2 cycles then released, no start → a=b=0, busy=0, done=0, err=0, err_cnt=0, state=00 for 5 cycles.
- From S0, start cmd=01 → DRIVE a=1,b=0; expected y0=0, y1=1; state=01 after E1; done pulses once at E1→E2; err=0.
- From S1, start cmd=11 → a=1,b=0 for one cycle; state=00; y1 expected 0 in CHECK; err=0.
- From S0, start cmd=10 → a=b=1 with y0=1 during DRIVE; state=10 at E1, then 00 at E2; y1=1 checked; err=0.
- Fault injection: force y0=0 during DRIVE of cmd=10 → err=1 and err_cnt=1 from E1. A start pulsed during busy is ignored (no extra done). Sixteen more injected failures → err_cnt saturates at 15.
- Reset asserted during DRIVE → next cycle a=b=0, busy=0, state=00, err=0, and no done pulse.
